// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared core definitions for the memory stage and the load/store helpers:
//   data_t / be_t     - datapath word and byte-enable types
//   opcode_t          - 7-bit major opcode, with OP_LOAD / OP_STORE
//   F3_*              - funct3 access-width encodings
//   mem_state_t       - memory stage FSM encoding
//   f3_legal()        - funct3 legality for a load or a store
//   misaligned()      - natural-alignment check for a funct3 width
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam int CORE_XLEN = 32;

    typedef logic [CORE_XLEN-1:0]   data_t;
    typedef logic [CORE_XLEN/8-1:0] be_t;
    typedef logic [6:0]             opcode_t;

    localparam opcode_t OP_LOAD  = 7'b0000011;
    localparam opcode_t OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !is_store;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    // funct3[1:0] carries the access size for every legal encoding.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
// Data cache request/ack bus.
//   master (memory stage): drives dc_req, dc_we, dc_addr, dc_wdata, dc_be;
//                          receives dc_ack, dc_rdata
//   slave  (data cache)  : the mirror image
// dc_rdata is only meaningful in the cycle dc_ack is high.
// -----------------------------------------------------------------------------
interface mem_access_if;
    import mem_access_pkg::*;

    logic  dc_req;
    logic  dc_we;
    data_t dc_addr;
    data_t dc_wdata;
    be_t   dc_be;
    logic  dc_ack;
    data_t dc_rdata;

    modport master (
        output dc_req, dc_we, dc_addr, dc_wdata, dc_be,
        input  dc_ack, dc_rdata
    );

    modport slave (
        input  dc_req, dc_we, dc_addr, dc_wdata, dc_be,
        output dc_ack, dc_rdata
    );

endinterface

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load alignment: picks the byte/halfword addressed by addr_lo
// out of the returned cache word and sign- or zero-extends it per funct3.
//   dc_rdata - word returned by the data cache
//   addr_lo  - low two bits of the effective address
//   funct3   - load width/sign selector
//   data_out - extended load value
// -----------------------------------------------------------------------------
module load_extend
    import mem_access_pkg::*;
(
    input  data_t      dc_rdata,
    input  logic [1:0] addr_lo,
    input  logic [2:0] funct3,
    output data_t      data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        data_out = dc_rdata;
        byte_sel = dc_rdata[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? dc_rdata[31:16] : dc_rdata[15:0];
        case (funct3)
            F3_B:    data_out = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_out = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data_out = {24'b0, byte_sel};
            F3_HU:   data_out = {16'b0, half_sel};
            default: data_out = dc_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory stage: runs one load or store against the data cache per instruction
// and returns a uniform one-cycle done pulse to writeback.
//   clk, rst              - core clock, asynchronous active-high reset
//   start                 - instruction valid, sampled only when idle
//   opcode, funct3        - instruction class and access width/sign
//   alu_out, rs2_data     - effective address, store data
//   dc                    - data cache request/ack bus (master side)
//   dcache_out            - registered, extended load result
//   done                  - one-cycle completion pulse
//   busy                  - stage is not idle
//   mem_err               - valid with done: misaligned or illegal funct3
// Non-memory instructions and rejected accesses complete one cycle after
// start without touching the cache.
// -----------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN/8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  opcode_t     opcode,
    input  logic [2:0]  funct3,
    input  data_t       alu_out,
    input  data_t       rs2_data,
    mem_access_if.master dc,
    output data_t       dcache_out,
    output logic        done,
    output logic        busy,
    output logic        mem_err
);

    localparam logic [1:0] S_IDLE   = MEM_IDLE;
    localparam logic [1:0] S_ACCESS = MEM_ACCESS;
    localparam logic [1:0] S_DONE   = MEM_DONE;

    logic [1:0]      state;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic            is_load;
    logic            is_store;
    logic            access_err;
    logic [BE_W-1:0] be_next;
    logic [XLEN-1:0] wdata_next;
    data_t           load_data;

    always_comb begin
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        access_err = !f3_legal(is_store, funct3) || misaligned(funct3, alu_out[1:0]);

        // Narrow stores replicate across lanes so the cache only needs the BEs.
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << alu_out[1:0];
                wdata_next = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << alu_out[1:0];
                wdata_next = {2{rs2_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = rs2_data;
            end
        endcase
    end

    // The extend sees the latched width/offset, so dc_rdata is interpreted for
    // the access in flight even if the upstream fields change.
    load_extend u_load_extend (
        .dc_rdata (dc.dc_rdata),
        .addr_lo  (addr_lo_q),
        .funct3   (funct3_q),
        .data_out (load_data)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            dc.dc_req   <= 1'b0;
            dc.dc_we    <= 1'b0;
            dc.dc_addr  <= '0;
            dc.dc_wdata <= '0;
            dc.dc_be    <= '0;
            dcache_out  <= '0;
            done        <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dcache_out <= '0;
                        if ((is_load || is_store) && !access_err) begin
                            state       <= S_ACCESS;
                            funct3_q    <= funct3;
                            addr_lo_q   <= alu_out[1:0];
                            dc.dc_req   <= 1'b1;
                            dc.dc_we    <= is_store;
                            dc.dc_addr  <= {alu_out[XLEN-1:2], 2'b00};
                            dc.dc_wdata <= wdata_next;
                            dc.dc_be    <= is_store ? be_next : '0;
                        end else begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            mem_err <= is_load || is_store;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dc.dc_ack) begin
                        state     <= S_DONE;
                        dc.dc_req <= 1'b0;
                        done      <= 1'b1;
                        mem_err   <= 1'b0;
                        if (!dc.dc_we) begin
                            dcache_out <= load_data;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done    <= 1'b0;
                    mem_err <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Directed scenarios followed by randomized transactions for mem_access. The
// bench plays the data cache (ack after a chosen number of wait cycles) and
// predicts every transaction from the architectural rules: access size,
// alignment, lane placement and sign extension as plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_access;
    import mem_access_pkg::*;

    localparam opcode_t OP_IMM = 7'b0010011;

    logic    clk;
    logic    rst;
    logic    start;
    opcode_t opcode;
    logic [2:0] funct3;
    data_t   alu_out;
    data_t   rs2_data;
    data_t   dcache_out;
    logic    done;
    logic    busy;
    logic    mem_err;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_access_if dc_bus ();

    mem_access #(.XLEN(32), .BE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .funct3     (funct3),
        .alu_out    (alu_out),
        .rs2_data   (rs2_data),
        .dc         (dc_bus.master),
        .dcache_out (dcache_out),
        .done       (done),
        .busy       (busy),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one instruction and acts as the cache. Expectations come from the
    // architectural rules; out_obs returns dcache_out after completion.
    task automatic do_txn(input string name, input opcode_t op, input logic [2:0] f3,
                          input data_t addr, input data_t wd, input data_t rd,
                          input int waits, output data_t out_obs);
        logic   is_ld, is_st, is_mem, legal, err;
        int     sz, off, exp_lat, exp_req, req_cycles, done_at;
        longint raw;
        data_t  exp_addr, exp_wdata, exp_out;
        logic [3:0] exp_be;

        is_ld  = (op == 7'b0000011);
        is_st  = (op == 7'b0100011);
        is_mem = is_ld || is_st;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                      : (f3 inside {3'd0, 3'd1, 3'd2});
        err = 1'b0;
        if (is_mem) begin
            if (!legal) err = 1'b1;
            else if ((addr % sz) != 0) err = 1'b1;
        end
        off      = int'(addr % 4);
        exp_addr = addr - (addr % 4);
        exp_be   = 4'b0;
        exp_wdata = wd;
        exp_out  = '0;
        if (is_st && !err) begin
            exp_be = 4'(((1 << sz) - 1) << off);
            if (sz == 1)      exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        end
        if (is_ld && !err) begin
            if (sz == 4) begin
                raw = longint'(rd);
            end else begin
                raw = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
                if (f3 < 3'd4 && raw >= (64'd1 << (8 * sz - 1)))
                    raw = raw - (64'd1 << (8 * sz));
            end
            exp_out = 32'(raw);
        end
        exp_lat = (is_mem && !err) ? 2 + waits : 1;
        exp_req = (is_mem && !err) ? waits + 1 : 0;

        @(negedge clk);
        start         = 1'b1;
        opcode        = op;
        funct3        = f3;
        alu_out       = addr;
        rs2_data      = wd;
        dc_bus.dc_ack = 1'($urandom_range(0, 1));   // stray ack while idle
        req_cycles = 0;
        done_at    = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(negedge clk);
            start         = 1'b0;
            dc_bus.dc_ack = 1'b0;
            dc_bus.dc_rdata = $urandom;
            if (dc_bus.dc_req === 1'b1) begin
                check({name, "_dc_addr"}, dc_bus.dc_addr, exp_addr);
                check({name, "_dc_we"},   32'(dc_bus.dc_we), 32'(is_st));
                check({name, "_dc_be"},   32'(dc_bus.dc_be), 32'(exp_be));
                if (is_st) check({name, "_dc_wdata"}, dc_bus.dc_wdata, exp_wdata);
                req_cycles++;
                if (req_cycles == waits + 1) begin
                    dc_bus.dc_ack   = 1'b1;
                    dc_bus.dc_rdata = rd;
                end
            end
            if (done === 1'b1) begin
                done_at = k;
                check({name, "_dcache_out"}, dcache_out, exp_out);
                check({name, "_mem_err"}, 32'(mem_err), 32'(err));
                check({name, "_busy_at_done"}, 32'(busy), 32'd1);
            end
        end
        check({name, "_latency"}, done_at, exp_lat);
        check({name, "_req_cycles"}, req_cycles, exp_req);
        @(negedge clk);
        dc_bus.dc_ack = 1'b0;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_req_off"}, 32'(dc_bus.dc_req), 32'd0);
        out_obs = dcache_out;
    endtask

    initial begin
        data_t   obs;
        opcode_t rop;
        logic [2:0] rf3;
        int      sel;

        rst = 1'b1;
        start = 1'b0;
        opcode = '0;
        funct3 = '0;
        alu_out = '0;
        rs2_data = '0;
        dc_bus.dc_ack = 1'b0;
        dc_bus.dc_rdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_dc_req",     32'(dc_bus.dc_req), 32'd0);
        check("rst_dc_we",      32'(dc_bus.dc_we), 32'd0);
        check("rst_dc_addr",    dc_bus.dc_addr, 32'd0);
        check("rst_dc_wdata",   dc_bus.dc_wdata, 32'd0);
        check("rst_dc_be",      32'(dc_bus.dc_be), 32'd0);
        check("rst_dcache_out", dcache_out, 32'd0);
        check("rst_done",       32'(done), 32'd0);
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_mem_err",    32'(mem_err), 32'd0);
        rst = 1'b0;

        // Directed scenarios
        do_txn("lw_100", OP_LOAD, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, obs);
        check("lw_100_value", obs, 32'hDEADBEEF);
        do_txn("lb_103", OP_LOAD, F3_B, 32'h103, 32'h0, 32'h80FF_0000, 3, obs);
        check("lb_103_value", obs, 32'hFFFF_FF80);
        do_txn("lbu_103", OP_LOAD, F3_BU, 32'h103, 32'h0, 32'h80FF_0000, 3, obs);
        check("lbu_103_value", obs, 32'h0000_0080);
        do_txn("lh_102", OP_LOAD, F3_H, 32'h102, 32'h0, 32'h8001_7FFF, 1, obs);
        check("lh_102_value", obs, 32'hFFFF_8001);
        do_txn("lhu_100", OP_LOAD, F3_HU, 32'h100, 32'h0, 32'h8001_F00D, 0, obs);
        check("lhu_100_value", obs, 32'h0000_F00D);
        do_txn("sh_202", OP_STORE, F3_H, 32'h202, 32'h1234ABCD, 32'h0, 1, obs);
        check("sh_202_value", obs, 32'h0);
        do_txn("sb_301", OP_STORE, F3_B, 32'h301, 32'h0000_005A, 32'h0, 0, obs);
        do_txn("lw_101_misal", OP_LOAD, F3_W, 32'h101, 32'h0, 32'h0, 0, obs);
        check("lw_101_value", obs, 32'h0);
        do_txn("sh_001_misal", OP_STORE, F3_H, 32'h001, 32'h0, 32'h0, 0, obs);
        do_txn("sbu_illegal", OP_STORE, F3_BU, 32'h100, 32'h0, 32'h0, 0, obs);
        do_txn("ld_f3_3_illegal", OP_LOAD, 3'b011, 32'h100, 32'h0, 32'h0, 0, obs);
        do_txn("op_imm", OP_IMM, 3'b000, 32'h100, 32'h0, 32'h0, 0, obs);

        // Second start while busy is ignored
        @(negedge clk);
        start = 1'b1; opcode = OP_IMM; funct3 = 3'b000; alu_out = 32'h40;
        @(negedge clk);
        check("busy_ign_done", 32'(done), 32'd1);
        start = 1'b1; opcode = OP_LOAD; funct3 = F3_W; alu_out = 32'h40;
        @(negedge clk);
        start = 1'b0;
        check("busy_ign_done_off", 32'(done), 32'd0);
        check("busy_ign_no_req", 32'(dc_bus.dc_req), 32'd0);
        check("busy_ign_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("busy_ign_no_req2", 32'(dc_bus.dc_req), 32'd0);
        check("busy_ign_no_done2", 32'(done), 32'd0);

        // Async reset in the middle of an access
        @(negedge clk);
        start = 1'b1; opcode = OP_LOAD; funct3 = F3_W; alu_out = 32'h80;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid_req_before", 32'(dc_bus.dc_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req_dropped", 32'(dc_bus.dc_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        do_txn("lw_after_rst", OP_LOAD, F3_W, 32'h80, 32'h0, 32'hCAFE_F00D, 1, obs);
        check("lw_after_rst_value", obs, 32'hCAFE_F00D);

        // Randomized transactions
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0, 1:    rop = OP_LOAD;
                2:       rop = OP_STORE;
                default: rop = ($urandom_range(0, 1) == 0) ? OP_IMM : 7'b0110011;
            endcase
            rf3 = 3'($urandom_range(0, 7));
            do_txn("rand", rop, rf3, 32'h1000 + $urandom_range(0, 255), $urandom,
                   $urandom, int'($urandom_range(0, 3)), obs);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the core. Sits between decode_execute and writeback.
- Takes the effective address (ALU result) and store data, and runs one load or store against the data cache over a req/ack handshake.
- Returns load data, sign- or zero-extended, as dcache_out, together with a one-cycle done pulse.
- Non-memory instructions pass through with a one-cycle done, so writeback sees a uniform completion signal.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- BE_W, XLEN/8, byte-enable width.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  instruction valid from decode_execute; sampled only in IDLE
- opcode  input  opcode_t(7)  instruction opcode
- funct3  input  3  width/sign selector
- alu_out  input  data_t  effective address
- rs2_data  input  data_t  store data
- dc_req  output  1  cache request
- dc_we  output  1  1=store, 0=load
- dc_addr  output  data_t  word-aligned address (low 2 bits zero)
- dc_wdata  output  data_t  lane-replicated store data
- dc_be  output  BE_W  byte enables (stores only; 0 for loads)
- dc_ack  input  1  cache completes request this cycle
- dc_rdata  input  data_t  load word, valid with dc_ack
- dcache_out  output  data_t  extended load result, registered
- done  output  1  completion pulse, one cycle
- busy  output  1  high whenever state is not IDLE
- mem_err  output  1  valid with done: misaligned access or illegal funct3

Behaviour:
- Reset: state=IDLE. dc_req, dc_we, dc_addr, dc_wdata, dc_be, dcache_out, done, busy and mem_err all reset to 0.
- States: IDLE, ACCESS, DONE.
- IDLE, start=1, opcode=LOAD(0000011) or STORE(0100011), legal and aligned:
  - Latch all request fields and go to ACCESS.
- IDLE, start=1, any other opcode:
  - Go to DONE with mem_err=0 and dcache_out=0.
- IDLE, start=1, memory opcode but illegal funct3 or misaligned:
  - Go to DONE with mem_err=1. No cache request is issued. dcache_out=0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- ACCESS:
  - dc_req=1 with stable addr/we/wdata/be until dc_ack.
  - On dc_ack: go to DONE.
  - Loads capture extended data into dcache_out.
  - Stores leave dcache_out=0.
  - dc_req deasserts the cycle after the ack (a registered output, so no back-to-back requests).
- Byte enables:
  - SB: 0001<<addr[1:0].
  - SH: 0011<<addr[1:0].
  - SW: 1111.
- Store data lanes: SB replicates byte [7:0] to all four lanes; SH replicates [15:0] to both halves; SW passes through.
- Load extract: select the byte/half at addr[1:0] from dc_rdata. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- DONE: done=1 for exactly one cycle, then IDLE. dcache_out holds until the next capture.
- Latency from the start cycle t:
  - Pass-through or error: done at t+1.
  - Memory access with ack on the first req cycle t+1: done at t+2.
  - Each extra wait cycle adds 1.
- start while busy is ignored. The upstream stage must hold the instruction until done.
- dc_ack outside ACCESS is ignored.
- Async rst mid-ACCESS: dc_req drops immediately, with no done. The cache must tolerate an abandoned request.

Decomposition:
- Shared core package holds:
  - opcode_t, data_t.
  - OP_LOAD and OP_STORE constants.
  - funct3 width encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - mem_state_t enum.
- One combinational sub-module, load_extend: inputs dc_rdata, addr[1:0] and funct3; output data_t. Reused by a later LSU.
- Store lane/BE generation stays inline.

Test Plan:
- LW at 0x100, dc_ack on first req cycle, dc_rdata=0xDEADBEEF -> dc_addr=0x100, dc_be=0, done at t+2, dcache_out=0xDEADBEEF, mem_err=0.
- LB at 0x103, dc_rdata=0x80FF_0000, ack after 3 wait cycles -> dc_req held 4 cycles, dcache_out=0xFFFFFF80, done at t+5. Same access as LBU -> 0x00000080.
- SH at 0x202, rs2_data=0x1234ABCD -> dc_addr=0x200, dc_we=1, dc_be=1100, dc_wdata=0xABCDABCD; done after ack, dcache_out=0.
- LW at 0x101 and SH at 0x001 -> no dc_req, done at t+1, mem_err=1, dcache_out=0.
- OP-IMM opcode with start -> done at t+1, no dc_req; second start while busy is ignored.
- Assert rst during ACCESS -> dc_req=0 in the same cycle, done never pulses. After release, a new LW completes normally.
